// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32E load/store unit driving a single bus master port
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.

module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_WIDTH  = 7
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_store_data,
  input  logic [3:0]  req_destination,
  output logic        bus_request,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_write_data,
  input  logic        bus_ready,
  input  logic [31:0] bus_read_data,
  output logic        rsp_valid,
  output logic        rsp_is_load,
  output logic [3:0]  rsp_destination,
  output logic [31:0] rsp_data,
  output logic        rsp_fault
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
    TIMEOUT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t state, state_next;
  logic [TIMEOUT_WIDTH-1:0] wait_count;

  logic        write_q, is_load_q, fault_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic [31:0] address_q, write_data_q, load_data_q;
  logic [3:0]  byte_enable_q, destination_q;

  logic        accept, timeout_hit, req_fault, funct3_legal, misalign_fault;
  logic [1:0]  offset;
  logic [3:0]  byte_enable;
  logic [31:0] write_data, load_extended;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign accept      = req_valid && (state == IDLE) && !flush;
  assign timeout_hit = TIMEOUT_EN && (wait_count == TIMEOUT_LAST);

  // Request decode: legality, natural-alignment offset, lane enables and replicated store data
  always_comb begin
    offset         = req_address[1:0];
    misalign_fault = 1'b0;
    case (req_funct3[1:0])
      2'b01: begin
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_fault = req_address[0];
`endif
        offset = {req_address[1], 1'b0};
      end
      2'b10: begin
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_fault = |req_address[1:0];
`endif
        offset = 2'b00;
      end
      default: ;
    endcase

    case (req_funct3)
      3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
      3'b100, 3'b101:         funct3_legal = !req_is_store;
      default:                funct3_legal = 1'b0;
    endcase
    req_fault = !funct3_legal || misalign_fault;

    case (req_funct3[1:0])
      2'b00: begin
        byte_enable = 4'b0001 << offset;
        write_data  = {4{req_store_data[7:0]}};
      end
      2'b01: begin
        byte_enable = 4'b0011 << offset;
        write_data  = {2{req_store_data[15:0]}};
      end
      default: begin
        byte_enable = 4'b1111;
        write_data  = req_store_data;
      end
    endcase
  end

  always_comb begin
    case (offset_q)
      2'd0:    lane_byte = bus_read_data[7:0];
      2'd1:    lane_byte = bus_read_data[15:8];
      2'd2:    lane_byte = bus_read_data[23:16];
      default: lane_byte = bus_read_data[31:24];
    endcase
    lane_half = offset_q[1] ? bus_read_data[31:16] : bus_read_data[15:0];
    case (funct3_q)
      3'b000:  load_extended = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_extended = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_extended = {24'h0, lane_byte};
      3'b101:  load_extended = {16'h0, lane_half};
      default: load_extended = bus_read_data;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_next;
  end

  // A flushed access still finishes on the bus; only its response is dropped
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_fault ? RESPOND : ACCESS;
      ACCESS: begin
        if (bus_ready || timeout_hit) state_next = flush ? IDLE : RESPOND;
        else if (flush)               state_next = DRAIN;
      end
      RESPOND: state_next = IDLE;
      DRAIN:   if (bus_ready || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wait_count <= '0;
    end else if ((state == ACCESS || state == DRAIN) && !bus_ready && !timeout_hit) begin
      wait_count <= wait_count + TIMEOUT_WIDTH'(1);
    end else begin
      wait_count <= '0;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      write_q       <= 1'b0;
      is_load_q     <= 1'b0;
      fault_q       <= 1'b0;
      funct3_q      <= 3'b000;
      offset_q      <= 2'b00;
      address_q     <= 32'h0;
      write_data_q  <= 32'h0;
      load_data_q   <= 32'h0;
      byte_enable_q <= 4'h0;
      destination_q <= 4'h0;
    end else if (accept) begin
      write_q       <= req_is_store;
      is_load_q     <= !req_is_store;
      fault_q       <= req_fault;
      funct3_q      <= req_funct3;
      offset_q      <= offset;
      address_q     <= {req_address[31:2], 2'b00};
      write_data_q  <= write_data;
      load_data_q   <= 32'h0;
      byte_enable_q <= byte_enable;
      destination_q <= req_is_store ? 4'h0 : req_destination;
    end else if (state == ACCESS) begin
      if (bus_ready) begin
        if (is_load_q) load_data_q <= load_extended;
      end else if (timeout_hit) begin
        fault_q <= 1'b1;
      end
    end
  end

  always_comb begin
    req_ready       = (state == IDLE);
    bus_request     = (state == ACCESS) || (state == DRAIN);
    bus_write       = bus_request && write_q;
    bus_address     = bus_request ? address_q : 32'h0;
    bus_byte_enable = bus_request ? byte_enable_q : 4'h0;
    bus_write_data  = bus_request ? write_data_q : 32'h0;
    rsp_valid       = (state == RESPOND) && !flush;
    rsp_is_load     = rsp_valid && is_load_q;
    rsp_destination = rsp_valid ? destination_q : 4'h0;
    rsp_data        = rsp_valid ? load_data_q : 32'h0;
    rsp_fault       = rsp_valid && fault_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined.

module tb_load_store_unit;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        nreset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_address = 32'h0;
  logic [31:0] req_store_data = 32'h0;
  logic [3:0]  req_destination = 4'h0;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_read_data = 32'h0;
  logic        req_ready, bus_request, bus_write, rsp_valid, rsp_is_load, rsp_fault;
  logic [31:0] bus_address, bus_write_data, rsp_data;
  logic [3:0]  bus_byte_enable, rsp_destination;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(7)) dut (
    .clock(clock), .nreset(nreset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_address(req_address), .req_store_data(req_store_data),
    .req_destination(req_destination),
    .bus_request(bus_request), .bus_write(bus_write), .bus_address(bus_address),
    .bus_byte_enable(bus_byte_enable), .bus_write_data(bus_write_data),
    .bus_ready(bus_ready), .bus_read_data(bus_read_data),
    .rsp_valid(rsp_valid), .rsp_is_load(rsp_is_load), .rsp_destination(rsp_destination),
    .rsp_data(rsp_data), .rsp_fault(rsp_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [3:0]  rd;
    logic [31:0] rdata;
    int          wt;
    int          e_bus;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_fault;
    logic [31:0] e_data;
    logic        e_load;
    logic [3:0]  e_dest;
    int          e_cycle;
  } op_t;

  int    checks = 0;
  int    errors = 0;
  string cur_tag = "reset";

  logic        obs_rsp_seen, obs_fault, obs_is_load, obs_rsp_after, obs_write, obs_stable;
  logic [31:0] obs_data, obs_addr, obs_wdata;
  logic [3:0]  obs_dest, obs_be;
  int          obs_rsp_cycle, obs_bus_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", cur_tag, name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs();
    chk("req_ready", req_ready, 1);
    chk("bus_request", bus_request, 0);
    chk("bus_write", bus_write, 0);
    chk("bus_address", bus_address, 0);
    chk("bus_byte_enable", bus_byte_enable, 0);
    chk("bus_write_data", bus_write_data, 0);
    chk("rsp_valid", rsp_valid, 0);
    chk("rsp_is_load", rsp_is_load, 0);
    chk("rsp_destination", rsp_destination, 0);
    chk("rsp_data", rsp_data, 0);
    chk("rsp_fault", rsp_fault, 0);
  endtask

  // Reference: access size, natural offset and extension computed arithmetically
  function automatic op_t model(input op_t o);
    op_t         e;
    int          size, off_raw, off;
    logic        legal, trap;
    logic [63:0] mask;
    logic [31:0] v;
    e = o;
    legal = o.st ? (o.f3 <= 3'd2) : (o.f3 <= 3'd2 || o.f3 == 3'd4 || o.f3 == 3'd5);
    size = (o.f3[1:0] == 2'd0) ? 1 : (o.f3[1:0] == 2'd1) ? 2 : 4;
    off_raw = int'(o.addr % 32'd4);
    off = off_raw - (off_raw % size);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (off_raw % size) != 0;
`else
    trap = 1'b0;
`endif
    e.e_addr = o.addr & 32'hFFFF_FFFC;
    e.e_be = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) e.e_wdata[8*i +: 8] = o.sdata[8*(i % size) +: 8];
    mask = (64'd1 << (8 * size)) - 64'd1;
    v = 32'((64'(o.rdata) >> (8 * off)) & mask);
    if (!o.f3[2] && size < 4 && v[8*size-1]) v = v | ~32'(mask);
    e.e_load = !o.st;
    e.e_dest = o.st ? 4'h0 : o.rd;
    if (!legal || trap) begin
      e.e_bus = 0; e.e_fault = 1'b1; e.e_data = 32'h0; e.e_cycle = 1;
    end else if (o.wt >= TO) begin
      e.e_bus = TO; e.e_fault = 1'b1; e.e_data = 32'h0; e.e_cycle = TO + 1;
    end else begin
      e.e_bus = o.wt + 1; e.e_fault = 1'b0; e.e_data = o.st ? 32'h0 : v; e.e_cycle = o.wt + 2;
    end
    return e;
  endfunction

  // Cycle 0 is the accept cycle; bus_ready is raised on ACCESS cycle number o.wt
  task automatic run_op(input op_t o);
    int acc;
    obs_rsp_seen = 0; obs_rsp_cycle = 0; obs_fault = 0; obs_data = 0; obs_is_load = 0;
    obs_dest = 0; obs_addr = 0; obs_be = 0; obs_wdata = 0; obs_write = 0; obs_stable = 1;
    @(posedge clock); #1;
    req_valid = 1; req_is_store = o.st; req_funct3 = o.f3; req_address = o.addr;
    req_store_data = o.sdata; req_destination = o.rd; bus_read_data = o.rdata; bus_ready = 0;
    @(posedge clock); #1;
    req_valid = 0;
    acc = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      bus_ready = bus_request && (acc == o.wt);
      @(negedge clock);
      if (bus_request) begin
        if (acc == 0) begin
          obs_addr = bus_address; obs_be = bus_byte_enable;
          obs_wdata = bus_write_data; obs_write = bus_write;
        end else if (obs_addr !== bus_address || obs_be !== bus_byte_enable ||
                     obs_wdata !== bus_write_data || obs_write !== bus_write) begin
          obs_stable = 0;
        end
        acc++;
      end
      if (rsp_valid) begin
        obs_rsp_seen = 1; obs_rsp_cycle = cyc; obs_fault = rsp_fault;
        obs_data = rsp_data; obs_is_load = rsp_is_load; obs_dest = rsp_destination;
      end
      @(posedge clock); #1;
      if (obs_rsp_seen) break;
    end
    bus_ready = 0;
    obs_rsp_after = rsp_valid;
    obs_bus_cycles = acc;
  endtask

  task automatic check_op(input op_t e);
    chk("rsp_seen", obs_rsp_seen, 1);
    chk("rsp_cycle", obs_rsp_cycle, e.e_cycle);
    chk("rsp_fault", obs_fault, e.e_fault);
    chk("rsp_data", obs_data, e.e_data);
    chk("rsp_is_load", obs_is_load, e.e_load);
    chk("rsp_destination", obs_dest, e.e_dest);
    chk("rsp_one_cycle", obs_rsp_after, 0);
    chk("bus_cycles", obs_bus_cycles, e.e_bus);
    if (e.e_bus > 0) begin
      chk("bus_address", obs_addr, e.e_addr);
      chk("bus_byte_enable", obs_be, e.e_be);
      chk("bus_write", obs_write, e.st);
      chk("bus_stable", obs_stable, 1);
      if (e.st) chk("bus_write_data", obs_wdata, e.e_wdata);
    end
  endtask

  op_t tbl[13];
  op_t r;

  initial begin
    tbl[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 4'd0, 32'h0, 0,
                1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 4'd0, 2};
    tbl[1]  = '{1'b0, 3'd2, 32'h100, 32'h0, 4'd5, 32'hDEADBEEF, 0,
                1, 32'h100, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 4'd5, 2};
    tbl[2]  = '{1'b0, 3'd0, 32'h203, 32'h0, 4'd1, 32'h80FF7F01, 0,
                1, 32'h200, 4'h8, 32'h0, 1'b0, 32'hFFFFFF80, 1'b1, 4'd1, 2};
    tbl[3]  = '{1'b0, 3'd4, 32'h203, 32'h0, 4'd2, 32'h80FF7F01, 1,
                2, 32'h200, 4'h8, 32'h0, 1'b0, 32'h00000080, 1'b1, 4'd2, 3};
    tbl[4]  = '{1'b0, 3'd0, 32'h201, 32'h0, 4'd3, 32'h80FF7F01, 0,
                1, 32'h200, 4'h2, 32'h0, 1'b0, 32'h0000007F, 1'b1, 4'd3, 2};
    tbl[5]  = '{1'b0, 3'd5, 32'h202, 32'h0, 4'd4, 32'h80FF7F01, 2,
                3, 32'h200, 4'hC, 32'h0, 1'b0, 32'h000080FF, 1'b1, 4'd4, 4};
    tbl[6]  = '{1'b1, 3'd0, 32'h302, 32'h000000AB, 4'd0, 32'h0, 0,
                1, 32'h300, 4'h4, 32'hABABABAB, 1'b0, 32'h0, 1'b0, 4'd0, 2};
    tbl[7]  = '{1'b1, 3'd1, 32'h302, 32'h00001234, 4'd0, 32'h0, 1,
                2, 32'h300, 4'hC, 32'h12341234, 1'b0, 32'h0, 1'b0, 4'd0, 3};
    tbl[8]  = '{1'b0, 3'd3, 32'h100, 32'h0, 4'd6, 32'h12345678, 0,
                0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b1, 4'd6, 1};
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[9]  = '{1'b0, 3'd2, 32'h102, 32'h0, 4'd7, 32'hCAFEF00D, 1,
                0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b1, 4'd7, 1};
`else
    tbl[9]  = '{1'b0, 3'd2, 32'h102, 32'h0, 4'd7, 32'hCAFEF00D, 1,
                2, 32'h100, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1, 4'd7, 3};
`endif
    tbl[10] = '{1'b0, 3'd2, 32'h400, 32'h0, 4'd8, 32'h55555555, 10,
                TO, 32'h400, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1, 4'd8, TO + 1};
    tbl[11] = '{1'b1, 3'd4, 32'h100, 32'h55, 4'd0, 32'h0, 0,
                0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0, 4'd0, 1};
    tbl[12] = '{1'b0, 3'd1, 32'h202, 32'h0, 4'd9, 32'h80FF7F01, 0,
                1, 32'h200, 4'hC, 32'h0, 1'b0, 32'hFFFF80FF, 1'b1, 4'd9, 2};

    #2 nreset = 0;
    @(negedge clock);
    chk_idle_outputs();
    nreset = 1;

    for (int i = 0; i < 13; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_op(tbl[i]);
      check_op(tbl[i]);
    end

    for (int i = 0; i < 40; i++) begin
      cur_tag = $sformatf("rand%0d", i);
      r.st = 1'($urandom_range(0, 1));
      r.f3 = 3'($urandom_range(0, 7));
      r.addr = $urandom;
      r.sdata = $urandom;
      r.rd = 4'($urandom_range(0, 15));
      r.rdata = $urandom;
      r.wt = $urandom_range(0, 5);
      r = model(r);
      run_op(r);
      check_op(r);
    end

    // Flush in ACCESS of a store: bus held stable through DRAIN, response dropped
    cur_tag = "flush_access";
    @(posedge clock); #1;
    req_valid = 1; req_is_store = 1; req_funct3 = 3'd2; req_address = 32'h300;
    req_store_data = 32'h11223344; bus_ready = 0;
    @(posedge clock); #1;
    req_valid = 0; flush = 1;
    for (int c = 1; c <= 6; c++) begin
      bus_ready = (c == 4);
      @(negedge clock);
      if (c <= 4) begin
        chk("bus_request", bus_request, 1);
        chk("bus_address", bus_address, 32'h300);
        chk("bus_byte_enable", bus_byte_enable, 4'hF);
        chk("bus_write_data", bus_write_data, 32'h11223344);
        chk("bus_write", bus_write, 1);
      end
      if (c == 5) begin
        chk("req_ready", req_ready, 1);
        chk("bus_request_after", bus_request, 0);
      end
      chk("rsp_valid", rsp_valid, 0);
      @(posedge clock); #1;
      flush = 0;
    end
    bus_ready = 0;

    cur_tag = "flush_respond";
    req_valid = 1; req_is_store = 0; req_funct3 = 3'd2; req_address = 32'h100;
    bus_read_data = 32'h0BADF00D;
    @(posedge clock); #1;
    req_valid = 0; bus_ready = 1;
    @(negedge clock);
    chk("bus_request", bus_request, 1);
    @(posedge clock); #1;
    bus_ready = 0; flush = 1;
    @(negedge clock);
    chk("rsp_valid", rsp_valid, 0);
    chk("rsp_data", rsp_data, 0);
    @(posedge clock); #1;
    flush = 0;
    @(negedge clock);
    chk("req_ready", req_ready, 1);
    chk("rsp_valid_late", rsp_valid, 0);

    cur_tag = "flush_idle";
    @(posedge clock); #1;
    req_valid = 1; flush = 1;
    @(posedge clock); #1;
    req_valid = 0; flush = 0;
    @(negedge clock);
    chk("bus_request", bus_request, 0);
    chk("req_ready", req_ready, 1);
    @(negedge clock);
    chk("rsp_valid", rsp_valid, 0);

    cur_tag = "async_reset";
    @(posedge clock); #1;
    req_valid = 1; req_is_store = 1; req_funct3 = 3'd2; req_address = 32'h500;
    req_store_data = 32'hA5A5A5A5;
    @(posedge clock); #1;
    req_valid = 0;
    @(negedge clock);
    chk("bus_request_before", bus_request, 1);
    #2 nreset = 0;
    #1 chk_idle_outputs();
    @(negedge clock);
    nreset = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("no_retry_bus", bus_request, 0);
      chk("no_retry_rsp", rsp_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
